// File: rtl/mem_arbiter_rr.sv
// Round-robin N-channel arbiter for one single-port sync RAM; 3 cycles per beat (IDLE/ISSUE/ACK), bursts capped at MAX_BURST.
// Requests are level-sensitive and held off while busy. Define MEMARB_PRIO_EN to add the ch_prio override input.
module mem_arbiter_rr #(
    parameter int NUM_CH    = 3,
    parameter int CH_W      = 2,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4,
    parameter int ADDR_INC  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          ch_req,
    input  logic [NUM_CH-1:0]          ch_burst,
    input  logic [NUM_CH-1:0]          ch_we,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
    input  logic [NUM_CH*DATA_W-1:0]   ch_di,
`ifdef MEMARB_PRIO_EN
    input  logic [NUM_CH-1:0]          ch_prio,
`endif
    output logic [NUM_CH-1:0]          ch_ack,
    output logic [DATA_W-1:0]          ch_do,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_di,
    input  logic [DATA_W-1:0]          mem_do,
    output logic [CH_W-1:0]            grant_id,
    output logic                       busy
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

    state_t              state;
    logic [BW-1:0]       beats;
    logic                owner_vld;
    logic [CH_W-1:0]     owner_id;

    logic                cont;
    logic [NUM_CH-1:0]   rr_mask;
    logic                rr_vld;
    logic [CH_W-1:0]     rr_id;
    logic [CH_W:0]       scan_sum;
    logic [CH_W-1:0]     scan_idx;
`ifdef MEMARB_PRIO_EN
    logic [NUM_CH-1:0]   prio_req;
`endif

    assign ch_do = mem_do;

    always_comb begin
        cont     = owner_vld && ch_req[owner_id] && ch_burst[owner_id] && (beats < BURST_MAX);
`ifdef MEMARB_PRIO_EN
        prio_req = ch_req & ch_prio;
        rr_mask  = (|prio_req) ? prio_req : ch_req;
        // Any other prioritised requester takes the next beat away from the burst owner.
        if (|(prio_req & ~(NUM_CH'(1) << owner_id)))
            cont = 1'b0;
`else
        rr_mask  = ch_req;
`endif
        rr_vld   = 1'b0;
        rr_id    = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            scan_sum = {1'b0, grant_id} + (CH_W+1)'(i);
            if (scan_sum >= (CH_W+1)'(NUM_CH))
                scan_sum = scan_sum - (CH_W+1)'(NUM_CH);
            scan_idx = scan_sum[CH_W-1:0];
            if (!rr_vld && rr_mask[scan_idx]) begin
                rr_vld = 1'b1;
                rr_id  = scan_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ch_ack    <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_di    <= '0;
            grant_id  <= CH_W'(NUM_CH - 1);
            busy      <= 1'b0;
            beats     <= '0;
            owner_vld <= 1'b0;
            owner_id  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cont) begin
                        mem_en   <= 1'b1;
                        mem_we   <= ch_we[owner_id];
                        mem_di   <= ch_di[owner_id*DATA_W +: DATA_W];
                        mem_addr <= mem_addr + ADDR_W'(ADDR_INC);
                        grant_id <= owner_id;
                        beats    <= beats + BW'(1);
                        if (beats + BW'(1) == BURST_MAX)
                            owner_vld <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end else begin
                        owner_vld <= 1'b0;
                        if (rr_vld) begin
                            mem_en    <= 1'b1;
                            mem_we    <= ch_we[rr_id];
                            mem_di    <= ch_di[rr_id*DATA_W +: DATA_W];
                            mem_addr  <= ch_addr[rr_id*ADDR_W +: ADDR_W];
                            grant_id  <= rr_id;
                            beats     <= BW'(1);
                            owner_vld <= ch_burst[rr_id] && (BW'(1) < BURST_MAX);
                            owner_id  <= rr_id;
                            busy      <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    mem_en <= 1'b0;
                    ch_ack <= NUM_CH'(1) << grant_id;
                    state  <= ACK;
                end
                ACK: begin
                    ch_ack <= '0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: behavioural RAM, scoreboard of expected accesses popped on each ch_ack.
module tb_mem_arbiter_rr;
    localparam int NUM_CH = 3, CH_W = 2, ADDR_W = 10, DATA_W = 32, MAX_BURST = 4, ADDR_INC = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [NUM_CH-1:0]        ch_req, ch_burst, ch_we, ch_ack;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*DATA_W-1:0] ch_di;
    logic [DATA_W-1:0]        ch_do, mem_di, mem_do;
    logic                     mem_en, mem_we, busy;
    logic [ADDR_W-1:0]        mem_addr;
    logic [CH_W-1:0]          grant_id;
`ifdef MEMARB_PRIO_EN
    logic [NUM_CH-1:0]        ch_prio = '0;
`endif

    mem_arbiter_rr #(.NUM_CH(NUM_CH), .CH_W(CH_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                     .MAX_BURST(MAX_BURST), .ADDR_INC(ADDR_INC)) dut (
        .clk(clk), .reset(reset), .ch_req(ch_req), .ch_burst(ch_burst), .ch_we(ch_we),
        .ch_addr(ch_addr), .ch_di(ch_di),
`ifdef MEMARB_PRIO_EN
        .ch_prio(ch_prio),
`endif
        .ch_ack(ch_ack), .ch_do(ch_do), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_di(mem_di), .mem_do(mem_do),
        .grant_id(grant_id), .busy(busy));

    typedef struct {
        int                ch;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] dat;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;

    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rd_q;
    assign mem_do = rd_q;

    function automatic logic [DATA_W-1:0] pat(input int a);
        return 32'h5A00_0000 ^ DATA_W'(a);
    endfunction

    function automatic logic [DATA_W-1:0] wdat(input int b);
        return 32'hC0DE_0000 + DATA_W'(b);
    endfunction

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = pat(i);
        ram[16] = 32'hDEADBEEF;
        rd_q = '0;
        forever begin
            @(posedge clk);
            if (mem_en) begin
                if (mem_we) ram[mem_addr] <= mem_di;
                else        rd_q <= ram[mem_addr];
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic push(input int ch, input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_t x;
        x.ch = ch; x.we = we; x.addr = a; x.dat = d;
        sb_q.push_back(x);
    endtask

    task automatic wait_ack(input logic [CH_W-1:0] ch);
        int   n = 0;
        logic got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            got = ch_ack[ch];
        end
        chk("ack_wait", {63'd0, got}, 64'd1);
    endtask

    // Access monitor: every ack must match the oldest expected access.
    logic [ADDR_W-1:0] iss_addr = '0;
    logic              iss_we   = 1'b0;
    logic [DATA_W-1:0] iss_di   = '0;
    always @(negedge clk) begin
        if (mem_en) begin
            iss_addr = mem_addr;
            iss_we   = mem_we;
            iss_di   = mem_di;
        end
        if (ch_ack != '0) begin
            chk("sb_has_entry", {63'd0, sb_q.size() != 0}, 64'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("ack_onehot", {61'd0, ch_ack}, 64'd1 << e.ch);
                chk("acc_addr", {54'd0, iss_addr}, {54'd0, e.addr});
                chk("acc_we", {63'd0, iss_we}, {63'd0, e.we});
                if (e.we) chk("wr_data", {32'd0, iss_di}, {32'd0, e.dat});
                else      chk("rd_data", {32'd0, ch_do}, {32'd0, e.dat});
            end
        end
    end

    int                prev;
    logic [ADDR_W-1:0] a;

    initial begin
        ch_req = '0; ch_burst = '0; ch_we = '0; ch_addr = '0; ch_di = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", {61'd0, ch_ack}, 64'd0);
        chk("rst_mem_en", {63'd0, mem_en}, 64'd0);
        chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
        chk("rst_mem_addr", {54'd0, mem_addr}, 64'd0);
        chk("rst_mem_di", {32'd0, mem_di}, 64'd0);
        chk("rst_grant_id", {62'd0, grant_id}, 64'd2);
        chk("rst_busy", {63'd0, busy}, 64'd0);

        // Single read by ch1
        reset = 1'b1;
        push(1, 1'b0, 10'h010, 32'hDEADBEEF);
        ch_addr[1*ADDR_W +: ADDR_W] = 10'h010;
        ch_req = 3'b010;
        @(posedge clk); #1;
        chk("t1_mem_en", {63'd0, mem_en}, 64'd1);
        chk("t1_grant", {62'd0, grant_id}, 64'd1);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        chk("t1_addr", {54'd0, mem_addr}, 64'h010);
        @(posedge clk); #1;
        chk("t1_mem_en_off", {63'd0, mem_en}, 64'd0);
        chk("t1_ack", {61'd0, ch_ack}, 64'b010);
        chk("t1_do", {32'd0, ch_do}, 64'hDEADBEEF);
        ch_req = '0;
        @(posedge clk); #1;
        chk("t1_ack_clear", {61'd0, ch_ack}, 64'd0);
        chk("t1_idle", {63'd0, busy}, 64'd0);

        // All three requesting from reset: 0,1,2,0,1,2, one ack every 3 cycles
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < NUM_CH; i++) ch_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(10'h020 + i);
        for (int k = 0; k < 6; k++) push(k % 3, 1'b0, ADDR_W'(10'h020 + k % 3), pat(32'h20 + k % 3));
        ch_req = 3'b111;
        prev = 0;
        for (int k = 0; k < 6; k++) begin
            wait_ack(CH_W'(k % 3));
            if (k > 0) chk("t2_ack_gap", 64'(cyc - prev), 64'd3);
            prev = cyc;
            if (k >= 3) ch_req[k % 3] = 1'b0;
        end

        // ch0 burst write wrapping the address space, ch2 pending behind it
        ch_we = 3'b001; ch_burst = 3'b001;
        ch_addr[0*ADDR_W +: ADDR_W] = 10'h3F8;
        ch_addr[2*ADDR_W +: ADDR_W] = 10'h030;
        ch_di[0 +: DATA_W] = wdat(0);
        for (int b = 0; b < 4; b++) begin
            a = 10'h3F8 + ADDR_W'(4 * b);
            push(0, 1'b1, a, wdat(b));
        end
        push(2, 1'b0, 10'h030, pat(32'h30));
        push(0, 1'b1, 10'h100, wdat(4));
        push(0, 1'b1, 10'h104, wdat(5));
        ch_req = 3'b101;
        for (int b = 0; b < 4; b++) begin
            wait_ack(2'd0);
            ch_di[0 +: DATA_W] = wdat(b + 1);
            if (b == 3) ch_addr[0*ADDR_W +: ADDR_W] = 10'h100;
        end
        wait_ack(2'd2);
        ch_req[2] = 1'b0;
        wait_ack(2'd0);
        ch_di[0 +: DATA_W] = wdat(5);
        wait_ack(2'd0);
        ch_req = '0; ch_burst = '0; ch_we = '0;
        chk("t3_ram_3f8", {32'd0, ram[10'h3F8]}, {32'd0, wdat(0)});
        chk("t3_ram_000", {32'd0, ram[10'h000]}, {32'd0, wdat(2)});
        chk("t3_ram_004", {32'd0, ram[10'h004]}, {32'd0, wdat(3)});

        // Reset in the middle of ISSUE: access dropped without ack
        ch_addr[1*ADDR_W +: ADDR_W] = 10'h040;
        ch_req = 3'b010;
        @(posedge clk);
        @(posedge clk); #1;
        chk("t4_issue", {63'd0, mem_en}, 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("t4_mem_en_clr", {63'd0, mem_en}, 64'd0);
        chk("t4_ack_clr", {61'd0, ch_ack}, 64'd0);
        chk("t4_busy_clr", {63'd0, busy}, 64'd0);
        chk("t4_grant_rst", {62'd0, grant_id}, 64'd2);
        @(posedge clk); #1;
        chk("t4_no_ack", {61'd0, ch_ack}, 64'd0);
        ch_addr[0*ADDR_W +: ADDR_W] = 10'h060;
        push(0, 1'b0, 10'h060, pat(32'h60));
        push(1, 1'b0, 10'h040, pat(32'h40));
        ch_req = 3'b011;
        reset = 1'b1;
        wait_ack(2'd0);
        ch_req[0] = 1'b0;
        wait_ack(2'd1);
        ch_req[1] = 1'b0;

        // ch1 drops its request during ISSUE; stray ch_burst[2] without request
        ch_addr[1*ADDR_W +: ADDR_W] = 10'h050;
        push(1, 1'b0, 10'h050, pat(32'h50));
        ch_req = 3'b010; ch_burst = 3'b100;
        @(posedge clk);
        @(posedge clk); #1;
        chk("t5_issue_grant", {62'd0, grant_id}, 64'd1);
        ch_req = '0;
        @(posedge clk); #1;
        chk("t5_ack", {61'd0, ch_ack}, 64'b010);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t5_no_regrant", {63'd0, mem_en}, 64'd0);
        chk("t5_not_busy", {63'd0, busy}, 64'd0);
        ch_burst = '0;

`ifdef MEMARB_PRIO_EN
        // Priority requester preempts ch0 burst after its second beat
        ch_addr[0*ADDR_W +: ADDR_W] = 10'h080;
        ch_addr[2*ADDR_W +: ADDR_W] = 10'h090;
        push(0, 1'b0, 10'h080, pat(32'h80));
        push(0, 1'b0, 10'h084, pat(32'h84));
        push(2, 1'b0, 10'h090, pat(32'h90));
        push(0, 1'b0, 10'h080, pat(32'h80));
        ch_burst = 3'b001; ch_req = 3'b001;
        wait_ack(2'd0);
        wait_ack(2'd0);
        ch_req[2] = 1'b1; ch_prio[2] = 1'b1;
        wait_ack(2'd2);
        ch_req[2] = 1'b0; ch_prio = '0;
        wait_ack(2'd0);
        ch_req = '0; ch_burst = '0;
`endif

        repeat (6) @(posedge clk);
        #1;
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        chk("final_ack", {61'd0, ch_ack}, 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
